// File: rtl/ece385_input_pkg.sv
// Shared types and channel indices for the board input front-end.
// The debounce FSM encoding lives here so every channel and checker uses one definition.
package ece385_input_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } db_state_t;

  localparam int BTN_RUN = 0;
  localparam int BTN_RLC = 1;

endpackage

// File: rtl/debounce_cell.sv
// One button channel: two-flop synchronizer, four-state debounce FSM,
// run-length counter and registered level/rising-edge pulse.
module debounce_cell
  import ece385_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic btn_raw,
  output logic level,
  output logic pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          meta;
  logic          s;
  db_state_t     state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          level_nx;
  logic          pulse_nx;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      meta <= 1'b0;
      s    <= 1'b0;
    end else begin
      meta <= btn_raw;
      s    <= meta;
    end
  end

  // The counter is cleared on every accepted transition and on every bounce,
  // so it never needs to count past DEBOUNCE_CYCLES-1.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    level_nx = level;
    pulse_nx = 1'b0;
    unique case (state)
      S_LOW: begin
        level_nx = 1'b0;
        cnt_nx   = '0;
        if (s) begin
          state_nx = S_RISE;
          cnt_nx   = CNT_ONE;
        end
      end
      S_RISE: begin
        if (!s) begin
          state_nx = S_LOW;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = S_HIGH;
          cnt_nx   = '0;
          level_nx = 1'b1;
          pulse_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      S_HIGH: begin
        level_nx = 1'b1;
        cnt_nx   = '0;
        if (!s) begin
          state_nx = S_FALL;
          cnt_nx   = CNT_ONE;
        end
      end
      S_FALL: begin
        if (s) begin
          state_nx = S_HIGH;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = S_LOW;
          cnt_nx   = '0;
          level_nx = 1'b0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nx = S_LOW;
        cnt_nx   = '0;
        level_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_LOW;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      level <= level_nx;
      pulse <= pulse_nx;
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Board input front-end: debounced buttons (level + rising pulse) and
// two-flop synchronized switches, all registered in the Clk domain.
module input_conditioner
  import ece385_input_pkg::*;
#(
  parameter int NUM_BTN         = 2,
  parameter int SW_W            = 8,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [NUM_BTN-1:0] btn_i,
  input  logic [SW_W-1:0]    sw_i,
  output logic [NUM_BTN-1:0] btn_level_o,
  output logic [NUM_BTN-1:0] btn_pulse_o,
  output logic [SW_W-1:0]    sw_o
);

  logic [SW_W-1:0] sw_meta;

  // Switches are static configuration, so synchronizing without debounce is enough.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sw_meta <= '0;
      sw_o    <= '0;
    end else begin
      sw_meta <= sw_i;
      sw_o    <= sw_meta;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .Clk    (Clk),
      .Reset_n(Reset_n),
      .btn_raw(btn_i[g]),
      .level  (btn_level_o[g]),
      .pulse  (btn_pulse_o[g])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DEBOUNCE_CYCLES=4: directed scenarios plus
// randomized bouncing checked against a run-length reference model.
module tb_input_conditioner;

  localparam int NUM_BTN = 2;
  localparam int SW_W    = 8;
  localparam int DB      = 4;

  logic               Clk     = 1'b0;
  logic               Reset_n = 1'b0;
  logic [NUM_BTN-1:0] btn_i   = '0;
  logic [SW_W-1:0]    sw_i    = '0;
  logic [NUM_BTN-1:0] btn_level_o;
  logic [NUM_BTN-1:0] btn_pulse_o;
  logic [SW_W-1:0]    sw_o;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 Clk = ~Clk;

  input_conditioner #(
    .NUM_BTN(NUM_BTN),
    .SW_W(SW_W),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .btn_i      (btn_i),
    .sw_i       (sw_i),
    .btn_level_o(btn_level_o),
    .btn_pulse_o(btn_pulse_o),
    .sw_o       (sw_o)
  );

  // Reference: inputs seen through a 2-cycle delay line; a level flips once the
  // delayed input has disagreed with it for DB consecutive cycles.
  logic [NUM_BTN-1:0] m_b1, m_b2, m_level, m_pulse;
  logic [SW_W-1:0]    m_sw1, m_sw2;
  int                 m_run [NUM_BTN];

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_b1 <= '0; m_b2 <= '0; m_level <= '0; m_pulse <= '0;
      m_sw1 <= '0; m_sw2 <= '0;
      for (int b = 0; b < NUM_BTN; b++) m_run[b] <= 0;
    end else begin
      for (int b = 0; b < NUM_BTN; b++) begin
        if (m_b2[b] != m_level[b]) begin
          if (m_run[b] == DB - 1) begin
            m_level[b] <= m_b2[b];
            m_pulse[b] <= m_b2[b];
            m_run[b]   <= 0;
          end else begin
            m_run[b]   <= m_run[b] + 1;
            m_pulse[b] <= 1'b0;
          end
        end else begin
          m_run[b]   <= 0;
          m_pulse[b] <= 1'b0;
        end
      end
      m_b1 <= btn_i;  m_b2 <= m_b1;
      m_sw1 <= sw_i;  m_sw2 <= m_sw1;
    end
  end

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    btn_i = 2'b11;
    sw_i = 8'hFF;
    settle(3);
    tests_run++;
    if (btn_level_o !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_level got=%b exp=00", btn_level_o);
    end
    tests_run++;
    if (btn_pulse_o !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_pulse got=%b exp=00", btn_pulse_o);
    end
    tests_run++;
    if (sw_o !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_sw got=%h exp=00", sw_o);
    end
    btn_i = 2'b00;
    sw_i = 8'h00;
    Reset_n = 1'b1;
    settle(4);
  endtask

  task automatic test_switch_sync();
    logic [SW_W-1:0] exp;
    sw_i = 8'hC5;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp = (k + 1 >= 2) ? 8'hC5 : 8'h00;
      tests_run++;
      if (sw_o !== exp || sw_o !== m_sw2) begin
        tests_failed++;
        $display("FAIL sw_c5 cycle=%0d got=%h exp=%h", k + 1, sw_o, exp);
      end
    end
    sw_i = 8'h07;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp = (k + 1 >= 2) ? 8'h07 : 8'hC5;
      tests_run++;
      if (sw_o !== exp) begin
        tests_failed++;
        $display("FAIL sw_07 cycle=%0d got=%h exp=%h", k + 1, sw_o, exp);
      end
    end
  endtask

  task automatic test_press();
    btn_i = 2'b01;
    for (int k = 0; k < 20; k++) begin
      tick();
      tests_run++;
      if (btn_level_o !== {1'b0, (k + 1 >= 6)} || btn_pulse_o !== {1'b0, (k + 1 == 6)} ||
          btn_level_o !== m_level || btn_pulse_o !== m_pulse) begin
        tests_failed++;
        $display("FAIL press cycle=%0d level=%b pulse=%b exp_level=%b exp_pulse=%b",
                 k + 1, btn_level_o, btn_pulse_o, {1'b0, (k + 1 >= 6)}, {1'b0, (k + 1 == 6)});
      end
    end
    btn_i = 2'b00;
    settle(12);
  endtask

  task automatic test_glitch();
    for (int j = 0; j < 15; j++) begin
      btn_i[0] = (j < 3);
      tick();
      tests_run++;
      if (btn_level_o[0] !== 1'b0 || btn_pulse_o[0] !== 1'b0 || btn_level_o !== m_level) begin
        tests_failed++;
        $display("FAIL glitch j=%0d level=%b pulse=%b exp=0/0", j, btn_level_o[0], btn_pulse_o[0]);
      end
    end
  endtask

  task automatic test_bounce();
    logic [4:0] seq;
    int pulses;
    seq = 5'b01101;
    pulses = 0;
    for (int j = 0; j < 20; j++) begin
      btn_i[0] = (j < 5) ? seq[j] : 1'b1;
      tick();
      if (btn_pulse_o[0] === 1'b1) pulses++;
      tests_run++;
      if (btn_pulse_o[0] !== (j == 10) || btn_level_o[0] !== (j >= 10) ||
          btn_pulse_o !== m_pulse || btn_level_o !== m_level) begin
        tests_failed++;
        $display("FAIL bounce j=%0d level=%b pulse=%b exp_level=%b exp_pulse=%b",
                 j, btn_level_o[0], btn_pulse_o[0], (j >= 10), (j == 10));
      end
    end
    tests_run++;
    if (pulses != 1) begin
      tests_failed++;
      $display("FAIL bounce_count got=%0d exp=1", pulses);
    end
  endtask

  task automatic test_release();
    for (int j = 0; j < 12; j++) begin
      btn_i[0] = 1'b0;
      tick();
      tests_run++;
      if (btn_level_o[0] !== (j < 5) || btn_pulse_o[0] !== 1'b0 || btn_level_o !== m_level) begin
        tests_failed++;
        $display("FAIL release j=%0d level=%b pulse=%b exp_level=%b exp_pulse=0",
                 j, btn_level_o[0], btn_pulse_o[0], (j < 5));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_p, exp_l;
    btn_i = 2'b11;
    for (int j = 0; j < 12; j++) begin
      tick();
      exp_p = (j == 5) ? 2'b11 : 2'b00;
      exp_l = (j >= 5) ? 2'b11 : 2'b00;
      tests_run++;
      if (btn_pulse_o !== exp_p || btn_level_o !== exp_l) begin
        tests_failed++;
        $display("FAIL both j=%0d level=%b pulse=%b exp_level=%b exp_pulse=%b",
                 j, btn_level_o, btn_pulse_o, exp_l, exp_p);
      end
    end
    btn_i = 2'b00;
    settle(12);
  endtask

  task automatic test_mid_reset();
    btn_i = 2'b01;
    settle(4);
    Reset_n = 1'b0;
    #1;
    tests_run++;
    if (btn_level_o !== 2'b00 || btn_pulse_o !== 2'b00 || sw_o !== 8'h00) begin
      tests_failed++;
      $display("FAIL mid_reset level=%b pulse=%b sw=%h exp=00/00/00", btn_level_o, btn_pulse_o, sw_o);
    end
    tick();
    Reset_n = 1'b1;
    for (int j = 0; j < 12; j++) begin
      tick();
      tests_run++;
      if (btn_pulse_o[0] !== (j == 5) || btn_level_o[0] !== (j >= 5) ||
          btn_pulse_o !== m_pulse || btn_level_o !== m_level) begin
        tests_failed++;
        $display("FAIL requalify j=%0d level=%b pulse=%b exp_level=%b exp_pulse=%b",
                 j, btn_level_o[0], btn_pulse_o[0], (j >= 5), (j == 5));
      end
    end
    btn_i = 2'b00;
    settle(12);
  endtask

  task automatic test_random();
    int hold [NUM_BTN];
    for (int b = 0; b < NUM_BTN; b++) hold[b] = 0;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < NUM_BTN; b++) begin
        if (hold[b] == 0) begin
          btn_i[b] = 1'($urandom_range(0, 1));
          hold[b]  = $urandom_range(1, 9);
        end
        hold[b]--;
      end
      if ($urandom_range(0, 7) == 0) sw_i = 8'($urandom);
      tick();
      tests_run++;
      if (btn_level_o !== m_level || btn_pulse_o !== m_pulse || sw_o !== m_sw2) begin
        tests_failed++;
        $display("FAIL random i=%0d level=%b/%b pulse=%b/%b sw=%h/%h (got/exp)",
                 i, btn_level_o, m_level, btn_pulse_o, m_pulse, sw_o, m_sw2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_switch_sync();
    test_press();
    test_glitch();
    test_bounce();
    test_release();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front-end stage between the board push-buttons/slide switches and the multiplier top level.
- Synchronizes raw button inputs (Run, Reset_Load_Clr) and the 8 switches into the Clk domain, and debounces each button.
- Provides each button as a clean level and as a single-cycle rising-edge pulse.
- The multiplier control FSM consumes the pulse for Run and the level for Reset_Load_Clr, so it never sees metastable, bouncing or repeated edges.

Parameters:
- NUM_BTN, 2, number of button channels; index 0 = Run, index 1 = Reset_Load_Clr.
- SW_W, 8, switch bus width.
- DEBOUNCE_CYCLES, 100000, consecutive stable Clk cycles required to accept a button change; legal range is 2 or more.

Ports:
- Clk  in  1  system clock; all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- btn_i  in  NUM_BTN  raw button levels, active-high, asynchronous.
- sw_i  in  SW_W  raw switch levels, asynchronous.
- btn_level_o  out  NUM_BTN  debounced button level.
- btn_pulse_o  out  NUM_BTN  one-cycle pulse on each debounced 0->1 transition.
- sw_o  out  SW_W  synchronized switches.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - All synchronizer flops, counters, btn_level_o, btn_pulse_o and sw_o are 0.
  - Every channel FSM is in S_LOW.
  - Any debounce in progress is discarded.
- Synchronizers:
  - Two-flop synchronizer on every btn_i bit and every sw_i bit.
  - sw_o equals sw_i delayed by exactly 2 cycles. No debounce is applied to switches.
- Per-button FSM, acting on the synchronized bit s. Counter width is $clog2(DEBOUNCE_CYCLES).
  - S_LOW: level 0, counter 0. If s=1, go to S_RISE with counter=1.
  - S_RISE:
    - If s=0, go to S_LOW and clear the counter (glitch rejected).
    - Else, if counter==DEBOUNCE_CYCLES-1, go to S_HIGH, set level to 1, and assert pulse for exactly that one cycle.
    - Else, increment the counter.
  - S_HIGH: level 1. If s=0, go to S_FALL with counter=1.
  - S_FALL:
    - If s=1, go to S_HIGH and clear the counter.
    - Else, if counter==DEBOUNCE_CYCLES-1, go to S_LOW and set level to 0. No pulse on the falling edge.
    - Else, increment the counter.
- Outputs are registered:
  - btn_level_o and btn_pulse_o come from flops updated on the transition edge.
  - Latency from a clean raw edge to the output change is 2+DEBOUNCE_CYCLES cycles.
- Boundary conditions:
  - A bounce of fewer than DEBOUNCE_CYCLES cycles produces no output change.
  - Every bounce restarts the count from 1.
  - A button held indefinitely produces exactly one pulse.
  - Channels are fully independent. Simultaneous edges on several buttons yield simultaneous pulses.
  - The counter never wraps, because it is cleared or saturates at the transition.
- No combinational path from any input to any output.

Decomposition:
- Shared package ece385_input_pkg:
  - typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} db_state_t.
  - localparam constants BTN_RUN=0 and BTN_RLC=1.
- Sub-module debounce_cell:
  - One channel: synchronizer, FSM, counter, level and pulse.
  - Parameterized by DEBOUNCE_CYCLES.
  - input_conditioner instantiates NUM_BTN copies via generate, plus the switch synchronizer.

Test Plan (DEBOUNCE_CYCLES=4, cycle 0 is the first edge after btn_i changes):
- Reset, sw_i=8'hC5 at cycle 0 -> sw_o=8'h00 through cycle 1 and 8'hC5 from cycle 2. Change to 8'h07 -> 8'h07 two cycles later.
- btn_i[0] 0->1 and held 20 cycles -> btn_level_o[0] rises at cycle 6. btn_pulse_o[0]=1 only at cycle 6. btn_i[1] outputs stay 0.
- btn_i[0] high for 3 cycles then low -> btn_level_o[0] and btn_pulse_o[0] remain 0 throughout.
- Bounce btn_i[0] = 1,0,1,1,0, then steady 1 -> single pulse, 6 cycles after the last 0->1 edge; level stays high afterwards.
- Release after accepted high, steady 0 -> level falls 6 cycles later; no pulse.
- Both buttons rise together -> both pulses asserted in the same cycle.
- Reset_n asserted mid-count (cycle 4) and released -> all outputs 0 immediately. A button still held re-qualifies fully and pulses at 6 cycles after release.
